// File: rtl/pixel_pkg.sv
// Shared types and widths for the pixel collection path.
// Contents:
//   PIXEL_W      - width of one packed RGB pixel
//   WORD_W       - width of one AXI4-Stream video word
//   pack_phase_t - packer phase; FLUSH is only reachable with TLAST_PAD_EN
//   axis_word_t  - payload loaded into the output register
package pixel_pkg;

    localparam int unsigned PIXEL_W = 24;
    localparam int unsigned WORD_W  = 32;

    typedef enum logic [2:0] {
        P0    = 3'd0,
        P1    = 3'd1,
        P2    = 3'd2,
        P3    = 3'd3,
        FLUSH = 3'd4
    } pack_phase_t;

    // eof marks the tlast word of the final line; it never leaves the block
    typedef struct packed {
        logic [WORD_W-1:0] tdata;
        logic              tlast;
        logic              tuser;
        logic              eof;
    } axis_word_t;

endpackage

// File: rtl/pixel_stream_packer_if.sv
// Pixel input handshake plus AXI4-Stream video output of the packer.
// Signals:
//   in_r/in_g/in_b, in_valid, in_ready                     - pixel side
//   out_tdata, out_tvalid, out_tready, out_tlast, out_tuser - stream side
// Modports:
//   master - the packer (consumes pixels, drives the stream)
//   slave  - the environment (supplies pixels, sinks the stream)
interface pixel_stream_packer_if;
    import pixel_pkg::*;

    logic [7:0]        in_r;
    logic [7:0]        in_g;
    logic [7:0]        in_b;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] out_tdata;
    logic              out_tvalid;
    logic              out_tready;
    logic              out_tlast;
    logic              out_tuser;

    modport master (
        input  in_r, in_g, in_b, in_valid, out_tready,
        output in_ready, out_tdata, out_tvalid, out_tlast, out_tuser
    );

    modport slave (
        output in_r, in_g, in_b, in_valid, out_tready,
        input  in_ready, out_tdata, out_tvalid, out_tlast, out_tuser
    );

endinterface

// File: rtl/axis_out_reg.sv
// Single-entry AXI4-Stream output register.
// Ports:
//   aclk, aresetn - clock, asynchronous active-low reset
//   load          - capture word this cycle (only when can_load_c is high)
//   word          - payload to capture
//   tready        - downstream accept
//   tdata/tvalid/tlast/tuser - registered stream outputs
//   done          - one-cycle pulse after the eof word is accepted
//   can_load_c    - register is empty or drains this cycle
module axis_out_reg
    import pixel_pkg::*;
(
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              load,
    input  axis_word_t        word,
    input  logic              tready,
    output logic [WORD_W-1:0] tdata,
    output logic              tvalid,
    output logic              tlast,
    output logic              tuser,
    output logic              done,
    output logic              can_load_c
);

    logic eof_q;

    assign can_load_c = !tvalid || tready;

    // Payload is held while stalled; tvalid drops on accept unless refilled
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tdata  <= '0;
            tvalid <= 1'b0;
            tlast  <= 1'b0;
            tuser  <= 1'b0;
            eof_q  <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= tvalid && tready && eof_q;
            if (load) begin
                tdata  <= word.tdata;
                tlast  <= word.tlast;
                tuser  <= word.tuser;
                eof_q  <= word.eof;
                tvalid <= 1'b1;
            end else if (tready) begin
                tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pixel_stream_packer.sv
// Packs in-order 24-bit RGB pixels into a dense 32-bit AXI4-Stream video
// bus (4 pixels -> 3 words), with tuser on start of frame and tlast on
// end of line derived from runtime frame dimensions.
// Build option: define TLAST_PAD_EN to allow line widths that are not a
// multiple of 4 (the partial word of each line is zero-padded and flushed).
// Ports:
//   aclk, aresetn  - clock, asynchronous active-low reset
//   x_size, y_size - pixels per line / lines per frame, sampled at frame start
//   bus            - pixel input and stream output (master modport)
//   frame_done     - pulse the cycle after the last word of a frame is accepted
module pixel_stream_packer
    import pixel_pkg::*;
#(
    parameter int unsigned DIM_W = 11
)
(
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DIM_W-1:0]      x_size,
    input  logic [DIM_W-1:0]      y_size,
    pixel_stream_packer_if.master bus,
    output logic                  frame_done
);

    pack_phase_t        phase_q, phase_d;
    logic [PIXEL_W-1:0] hold_q, hold_d;
    logic [DIM_W-1:0]   x_q, x_d;
    logic [DIM_W-1:0]   y_q, y_d;
    logic [DIM_W-1:0]   xs_q, xs_d;
    logic [DIM_W-1:0]   ys_q, ys_d;
    logic               sof_pend_q, sof_pend_d;
`ifdef TLAST_PAD_EN
    logic               flush_eof_q, flush_eof_d;
`endif

    logic [PIXEL_W-1:0] pix_c;
    logic [DIM_W-1:0]   x_sel_c;
    logic [DIM_W-1:0]   y_sel_c;
    logic [DIM_W-1:0]   width_c;
    logic [DIM_W-1:0]   height_c;
    logic               in_ready_c;
    logic               can_load_c;
    logic               accept_c;
    logic               sof_c;
    logic               sof_flag_c;
    logic               x_last_c;
    logic               y_last_c;
    logic               load_c;
    axis_word_t         word_c;

    assign pix_c = {bus.in_r, bus.in_g, bus.in_b};

    // Ready depends only on registered state and out_tready
`ifdef TLAST_PAD_EN
    assign in_ready_c = can_load_c && (phase_q != FLUSH);
`else
    assign in_ready_c = can_load_c;
`endif
    assign bus.in_ready = in_ready_c;
    assign accept_c     = bus.in_valid && in_ready_c;

    // The first pixel of a frame uses the live sizes; later pixels the shadows
    assign sof_c   = (x_q == '0) && (y_q == '0);
    assign x_sel_c = sof_c ? x_size : xs_q;
    assign y_sel_c = sof_c ? y_size : ys_q;

    // Effective line width and frame height
    always_comb begin
`ifdef TLAST_PAD_EN
        width_c = (x_sel_c == '0) ? DIM_W'(1) : x_sel_c;
`else
        width_c = {x_sel_c[DIM_W-1:2], 2'b00};
        if (width_c == '0) begin
            width_c = DIM_W'(4);
        end
`endif
        height_c = (y_sel_c == '0) ? DIM_W'(1) : y_sel_c;
    end

`ifndef TLAST_PAD_EN
    logic unused_lsb_c;
    assign unused_lsb_c = ^x_sel_c[1:0];
`endif

    assign x_last_c = (x_q == DIM_W'(width_c - 1'b1));
    assign y_last_c = (y_q == DIM_W'(height_c - 1'b1));

    // Packing state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            phase_q     <= P0;
            hold_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            xs_q        <= '0;
            ys_q        <= '0;
            sof_pend_q  <= 1'b0;
`ifdef TLAST_PAD_EN
            flush_eof_q <= 1'b0;
`endif
        end else begin
            phase_q     <= phase_d;
            hold_q      <= hold_d;
            x_q         <= x_d;
            y_q         <= y_d;
            xs_q        <= xs_d;
            ys_q        <= ys_d;
            sof_pend_q  <= sof_pend_d;
`ifdef TLAST_PAD_EN
            flush_eof_q <= flush_eof_d;
`endif
        end
    end

    // Next-state: phase walk, counters, shadows and word assembly
    always_comb begin
        phase_d     = phase_q;
        hold_d      = hold_q;
        x_d         = x_q;
        y_d         = y_q;
        xs_d        = xs_q;
        ys_d        = ys_q;
        sof_pend_d  = sof_pend_q;
`ifdef TLAST_PAD_EN
        flush_eof_d = flush_eof_q;
`endif
        load_c      = 1'b0;
        word_c      = '0;

        // tuser rides on the first word loaded after the frame's first pixel
        sof_flag_c   = sof_pend_q || (accept_c && sof_c);
        word_c.tuser = sof_flag_c;

        if (accept_c) begin
            if (sof_c) begin
                xs_d = x_size;
                ys_d = y_size;
            end
            if (x_last_c) begin
                x_d = '0;
                y_d = y_last_c ? '0 : DIM_W'(y_q + 1'b1);
            end else begin
                x_d = DIM_W'(x_q + 1'b1);
            end

            unique case (phase_q)
                P0: begin
                    hold_d  = pix_c;
                    phase_d = P1;
`ifdef TLAST_PAD_EN
                    if (x_last_c) begin
                        load_c       = 1'b1;
                        word_c.tdata = {8'h00, pix_c};
                        word_c.tlast = 1'b1;
                        word_c.eof   = y_last_c;
                        phase_d      = P0;
                    end
`endif
                end
                P1: begin
                    load_c       = 1'b1;
                    word_c.tdata = {pix_c[7:0], hold_q};
                    hold_d       = {8'h00, pix_c[23:8]};
                    phase_d      = P2;
`ifdef TLAST_PAD_EN
                    if (x_last_c) begin
                        phase_d     = FLUSH;
                        flush_eof_d = y_last_c;
                    end
`endif
                end
                P2: begin
                    load_c       = 1'b1;
                    word_c.tdata = {pix_c[15:0], hold_q[15:0]};
                    hold_d       = {16'h0000, pix_c[23:16]};
                    phase_d      = P3;
`ifdef TLAST_PAD_EN
                    if (x_last_c) begin
                        phase_d     = FLUSH;
                        flush_eof_d = y_last_c;
                    end
`endif
                end
                P3: begin
                    load_c       = 1'b1;
                    word_c.tdata = {pix_c, hold_q[7:0]};
                    word_c.tlast = x_last_c;
                    word_c.eof   = x_last_c && y_last_c;
                    phase_d      = P0;
                end
                default: begin
                    phase_d = P0;
                end
            endcase
        end
`ifdef TLAST_PAD_EN
        // hold is kept zero-extended, so the padded tail is {8'h00, hold}
        else if ((phase_q == FLUSH) && can_load_c) begin
            load_c       = 1'b1;
            word_c.tdata = {8'h00, hold_q};
            word_c.tlast = 1'b1;
            word_c.eof   = flush_eof_q;
            phase_d      = P0;
        end
`endif

        sof_pend_d = load_c ? 1'b0 : sof_flag_c;
    end

    axis_out_reg u_out (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .load       (load_c),
        .word       (word_c),
        .tready     (bus.out_tready),
        .tdata      (bus.out_tdata),
        .tvalid     (bus.out_tvalid),
        .tlast      (bus.out_tlast),
        .tuser      (bus.out_tuser),
        .done       (frame_done),
        .can_load_c (can_load_c)
    );

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Scoreboard bench for pixel_stream_packer: a byte-stream reference model
// pushes expected words per frame, a monitor pops them on each handshake.
module tb_pixel_stream_packer;

    localparam int unsigned DIM_W = 11;

    typedef struct {
        logic [31:0] tdata;
        logic        tlast;
        logic        tuser;
        logic        eof;
    } exp_t;

    logic             aclk = 1'b0;
    logic             aresetn;
    logic [DIM_W-1:0] x_size;
    logic [DIM_W-1:0] y_size;
    logic             frame_done;

    pixel_stream_packer_if bus ();

    pixel_stream_packer #(.DIM_W(DIM_W)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .x_size     (x_size),
        .y_size     (y_size),
        .bus        (bus),
        .frame_done (frame_done)
    );

    always #5 aclk = ~aclk;

    exp_t        exp_q[$];
    int          checks     = 0;
    int          errors     = 0;
    int          frames_exp = 0;
    int          done_seen  = 0;
    int          bp_mode    = 0;   // 0 ready, 1 random, 2 stall 5 after first word, 3 held low
    int          stall_cnt  = 0;
    bit          stall_done = 1'b1;
    bit          gap_en     = 1'b0;
    logic [23:0] tp_pix[4];

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(bus.out_tvalid === 1'b0, {tag, "_tvalid"}, 32'(bus.out_tvalid), 0);
        chk(bus.out_tdata === 32'h0, {tag, "_tdata"}, bus.out_tdata, 0);
        chk(bus.out_tlast === 1'b0, {tag, "_tlast"}, 32'(bus.out_tlast), 0);
        chk(bus.out_tuser === 1'b0, {tag, "_tuser"}, 32'(bus.out_tuser), 0);
        chk(frame_done === 1'b0, {tag, "_frame_done"}, 32'(frame_done), 0);
        chk(bus.in_ready === 1'b1, {tag, "_in_ready"}, 32'(bus.in_ready), 1);
    endtask

    // Called and returns at posedge+1; presents one pixel until accepted
    task automatic send_pixel(input logic [23:0] p);
        bit done;
        done = 1'b0;
        if (gap_en) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge aclk);
                #1;
            end
        end
        bus.in_valid = 1'b1;
        {bus.in_r, bus.in_g, bus.in_b} = p;
        for (int n = 0; n < 500 && !done; n++) begin
            @(negedge aclk);
            done = bus.in_ready;
            @(posedge aclk);
            #1;
        end
        bus.in_valid = 1'b0;
        chk(done, "pixel_accept_timeout", 32'(done), 1);
    endtask

    // Reference: each line is a byte stream b,g,r per pixel, zero padded
    // to whole words, chopped little-endian into 32-bit words.
    task automatic run_frame(input int xs, input int ys, input int xs_mid, input int pmode);
        int          w;
        int          h;
        int          nw;
        int          xi;
        bit          loads;
        logic [23:0] p;
        logic [23:0] pix[$];
        logic [7:0]  bq[$];
        exp_t        e;
`ifdef TLAST_PAD_EN
        w = (xs == 0) ? 1 : xs;
`else
        w = xs & ~3;
        if (w == 0) w = 4;
`endif
        h = (ys == 0) ? 1 : ys;
        for (int i = 0; i < w * h; i++) begin
            case (pmode)
                0:       pix.push_back(24'($urandom));
                1:       pix.push_back(24'(i + 1));
                default: pix.push_back(tp_pix[i % 4]);
            endcase
        end
        for (int l = 0; l < h; l++) begin
            bq.delete();
            for (int x = 0; x < w; x++) begin
                p = pix[l * w + x];
                bq.push_back(p[7:0]);
                bq.push_back(p[15:8]);
                bq.push_back(p[23:16]);
            end
            while (bq.size() % 4 != 0) bq.push_back(8'h00);
            nw = bq.size() / 4;
            for (int k = 0; k < nw; k++) begin
                e.tdata = {bq[4*k+3], bq[4*k+2], bq[4*k+1], bq[4*k]};
                e.tlast = (k == nw - 1);
                e.tuser = (l == 0) && (k == 0);
                e.eof   = e.tlast && (l == h - 1);
                exp_q.push_back(e);
            end
        end
        frames_exp++;

        x_size = DIM_W'(xs);
        y_size = DIM_W'(ys);
        for (int i = 0; i < w * h; i++) begin
            xi = i % w;
            send_pixel(pix[i]);
            if (i == 0 && xs_mid >= 0) x_size = DIM_W'(xs_mid);
            loads = (xi % 4) != 0;
`ifdef TLAST_PAD_EN
            if (xi == w - 1) loads = 1'b1;
`endif
            if (loads) chk(bus.out_tvalid === 1'b1, "word_latency", 32'(bus.out_tvalid), 1);
`ifdef TLAST_PAD_EN
            if (xi == w - 1 && (w % 4 == 2 || w % 4 == 3)) begin
                @(negedge aclk);
                chk(bus.in_ready === 1'b0, "flush_in_ready", 32'(bus.in_ready), 0);
                @(posedge aclk);
                #1;
            end
`endif
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 3000 && exp_q.size() != 0; n++) @(posedge aclk);
        chk(exp_q.size() == 0, "drain_words_left", 32'(exp_q.size()), 0);
        repeat (3) @(posedge aclk);
        #1;
    endtask

    // Backpressure generator
    initial begin
        bus.out_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            case (bp_mode)
                1: bus.out_tready = ($urandom_range(0, 9) < 7);
                2: begin
                    if (!stall_done && bus.out_tvalid) begin
                        stall_cnt  = 5;
                        stall_done = 1'b1;
                    end
                    if (stall_cnt > 0) begin
                        bus.out_tready = 1'b0;
                        stall_cnt--;
                    end else begin
                        bus.out_tready = 1'b1;
                    end
                end
                3:       bus.out_tready = 1'b0;
                default: bus.out_tready = 1'b1;
            endcase
        end
    end

    // Monitor: handshakes, hold stability, ready rule, frame_done timing
    initial begin
        exp_t        e;
        bit          prev_stall = 1'b0;
        bit          prev_eof   = 1'b0;
        logic [33:0] prev_w     = '0;
        forever begin
            @(negedge aclk);
            if (aresetn !== 1'b1) begin
                prev_stall = 1'b0;
                prev_eof   = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk(bus.out_tvalid === 1'b1 &&
                        {bus.out_tdata, bus.out_tlast, bus.out_tuser} === prev_w,
                        "hold_stable", bus.out_tdata, prev_w[33:2]);
                end
`ifdef TLAST_PAD_EN
                if (bus.in_ready === 1'b1) begin
                    chk(!bus.out_tvalid || bus.out_tready, "in_ready_rule",
                        32'(bus.in_ready), 32'(!bus.out_tvalid || bus.out_tready));
                end
`else
                chk(bus.in_ready === (!bus.out_tvalid || bus.out_tready), "in_ready_rule",
                    32'(bus.in_ready), 32'(!bus.out_tvalid || bus.out_tready));
`endif
                if (frame_done === 1'b1 || prev_eof) begin
                    chk(frame_done === prev_eof, "frame_done", 32'(frame_done), 32'(prev_eof));
                end
                if (frame_done === 1'b1) done_seen++;
                prev_eof = 1'b0;
                if (bus.out_tvalid === 1'b1 && bus.out_tready === 1'b1) begin
                    chk(exp_q.size() != 0, "unexpected_word", bus.out_tdata, 0);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk(bus.out_tdata === e.tdata, "tdata", bus.out_tdata, e.tdata);
                        chk(bus.out_tlast === e.tlast, "tlast", 32'(bus.out_tlast), 32'(e.tlast));
                        chk(bus.out_tuser === e.tuser, "tuser", 32'(bus.out_tuser), 32'(e.tuser));
                        prev_eof = e.eof;
                    end
                end
                prev_stall = (bus.out_tvalid === 1'b1) && (bus.out_tready === 1'b0);
                prev_w     = {bus.out_tdata, bus.out_tlast, bus.out_tuser};
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int xs;
        int ys;
        tp_pix[0] = 24'h112233;
        tp_pix[1] = 24'h445566;
        tp_pix[2] = 24'h778899;
        tp_pix[3] = 24'hAABBCC;
        aresetn      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_r     = '0;
        bus.in_g     = '0;
        bus.in_b     = '0;
        x_size       = DIM_W'(4);
        y_size       = DIM_W'(1);
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_reset_outputs("reset");
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        // Four fixed pixels, free-running sink
        run_frame(4, 1, -1, 2);
        drain();

        // Same stream with a 5-cycle stall on the first word
        stall_done = 1'b0;
        bp_mode    = 2;
        run_frame(4, 1, -1, 2);
        drain();

        // Two 8-pixel lines with random gaps and backpressure
        gap_en  = 1'b1;
        bp_mode = 1;
        run_frame(8, 2, -1, 1);
        drain();

        // Width change mid-frame only takes effect on the next frame
        run_frame(8, 1, 4, 0);
        run_frame(4, 1, -1, 0);
        drain();

        // Reset after two accepted pixels with the first word stalled
        gap_en  = 1'b0;
        bp_mode = 3;
        repeat (2) @(posedge aclk);
        #1;
        x_size = DIM_W'(4);
        y_size = DIM_W'(1);
        send_pixel(24'h010203);
        send_pixel(24'h040506);
        aresetn = 1'b0;
        @(negedge aclk);
        check_reset_outputs("midreset");
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        bp_mode = 0;
        run_frame(4, 1, -1, 2);
        drain();

`ifdef TLAST_PAD_EN
        run_frame(5, 1, -1, 1);
        drain();
        run_frame(6, 1, -1, 1);
        drain();
        run_frame(7, 2, -1, 1);
        drain();
`endif

        // Back-to-back random frames
        for (int f = 0; f < 12; f++) begin
`ifdef TLAST_PAD_EN
            xs = $urandom_range(1, 9);
`else
            xs = $urandom_range(1, 13);
`endif
            ys      = $urandom_range(1, 3);
            bp_mode = $urandom_range(0, 1);
            gap_en  = 1'($urandom_range(0, 1));
            run_frame(xs, ys, -1, 0);
        end
        drain();

        chk(done_seen == frames_exp, "frame_done_count", 32'(done_seen), 32'(frames_exp));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
